// File: rtl/pc_sequencer.sv
// PC / EPC write sequencer for the multicycle datapath.
// Single-cycle PC updates plus a save/vector/wait/load exception sequence.
module pc_sequencer #(
   parameter int MEM_LATENCY = 2,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pc_req,
   input  logic [1:0] pc_kind,
   input  logic       exc_req,
   input  logic [1:0] exc_cause,
   output logic [2:0] pc_source,
   output logic       pc_write,
   output logic       epc_write,
   output logic       busy,
   output logic       exc_done,
   output logic       double_fault
);

   typedef enum logic [2:0] {
      IDLE,
      SAVE,
      VEC,
      WAIT,
      LOAD
   } state_t;

   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       cause, cause_n;
   logic [2:0]       src_n;
   logic             pcw_n;
   logic             epcw_n;
   logic             busy_n;
   logic             done_n;
   logic             df_n;
   logic [2:0]       vec_src;

   always_comb begin
      vec_src = 3'b101;
      unique case (1'b1)
         (cause == 2'b01): vec_src = 3'b110;
         (cause == 2'b10): vec_src = 3'b111;
         default:          vec_src = 3'b101;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cause_n = cause;
      src_n   = pc_source;
      pcw_n   = 1'b0;
      epcw_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      df_n    = double_fault;

      unique case (state)
         IDLE: begin
            if (exc_req) begin
               state_n = SAVE;
               cause_n = (exc_cause == 2'b11) ? 2'b00 : exc_cause;
               epcw_n  = 1'b1;
               src_n   = 3'b000;
               busy_n  = 1'b1;
            end else if (pc_req) begin
               pcw_n = 1'b1;
               src_n = {1'b0, pc_kind};
            end
         end
         SAVE: begin
            state_n = VEC;
            cnt_n   = LAT;
            pcw_n   = 1'b1;
            src_n   = vec_src;
            busy_n  = 1'b1;
         end
         VEC: begin
            state_n = WAIT;
            busy_n  = 1'b1;
         end
         WAIT: begin
            busy_n = 1'b1;
            // Count is pre-loaded, so the last wait cycle sees cnt == 1
            if (cnt == CNT_W'(1)) begin
               state_n = LOAD;
               pcw_n   = 1'b1;
               src_n   = 3'b100;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         LOAD: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (state != IDLE && exc_req) begin
         df_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         cause        <= 2'b00;
         pc_source    <= 3'b000;
         pc_write     <= 1'b0;
         epc_write    <= 1'b0;
         busy         <= 1'b0;
         exc_done     <= 1'b0;
         double_fault <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         cause        <= cause_n;
         pc_source    <= src_n;
         pc_write     <= pcw_n;
         epc_write    <= epcw_n;
         busy         <= busy_n;
         exc_done     <= done_n;
         double_fault <= df_n;
      end
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered controller that drives the 3-bit PC source select, PC write enable and EPC write enable of the multicycle datapath. Normal PC updates are single-cycle. Exceptions run a multi-cycle sequence:
- save EPC;
- point PC at the vector byte address (253/254/255);
- wait for memory;
- load PC from the zero-extended vector byte.

It sits between the main control FSM and the PC/EPC registers plus the PC source mux.

Parameters:
MEM_LATENCY, 2, cycles between PC update to vector address and vector byte valid on the exception input; legal 1..15
CNT_W, 4, width of the internal wait counter; must hold MEM_LATENCY

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
pc_req  input  1  one-cycle strobe from control: perform normal PC update
pc_kind  input  2  update type with pc_req: 00 ALU (PC+4), 01 ALUOut (branch), 10 instruction (jump), 11 EPC (rte)
exc_req  input  1  one-cycle strobe: exception raised
exc_cause  input  2  with exc_req: 00 invalid opcode, 01 overflow, 10 divide by zero, 11 reserved
pc_source  output  3  PC source mux select
pc_write  output  1  PC register load enable
epc_write  output  1  EPC register load enable
busy  output  1  exception sequence in progress
exc_done  output  1  one-cycle pulse on final vector-load cycle
double_fault  output  1  sticky flag: exc_req received while busy

Behaviour:
- All outputs registered. On reset: pc_source=000, pc_write=0, epc_write=0, busy=0, exc_done=0, double_fault=0; FSM=IDLE, counter=0, latched cause=00.
- Reset overrides everything, including mid-sequence: next cycle is IDLE with reset values.
- States: IDLE, SAVE, VEC, WAIT, LOAD.
- IDLE:
  - pc_req at cycle N (no exc_req): at N+1, pc_write=1 and pc_source={0,pc_kind} for exactly one cycle.
  - Otherwise pc_write=0 and pc_source holds its last value.
- Exception entry and priority:
  - exc_req in IDLE latches exc_cause and goes to SAVE.
  - exc_req wins over a simultaneous pc_req; that pc_req is dropped.
  - Reserved cause 11 is treated as 00.
- SAVE (1 cycle): epc_write=1, pc_write=0, pc_source=000, busy=1. EPC captures the ALU value (PC-4) supplied by the datapath.
- VEC (1 cycle): pc_write=1, pc_source = 101 (cause 00), 110 (cause 01), 111 (cause 10), busy=1. Loads counter with MEM_LATENCY.
- WAIT (exactly MEM_LATENCY cycles): pc_write=0, epc_write=0, pc_source holds its VEC value, busy=1. Counter decrements each cycle; leave when it reaches 1.
- LOAD (1 cycle): pc_source=100, pc_write=1, exc_done=1, busy=1. Then IDLE.
- Exception timeline, exc_req at N with MEM_LATENCY=L:
  - SAVE at N+1, VEC at N+2;
  - WAIT from N+3 to N+2+L;
  - LOAD at N+3+L;
  - busy deasserts at N+4+L.
- Requests while busy:
  - pc_req is ignored, with no queueing.
  - exc_req is ignored for sequencing but sets double_fault, which is cleared only by reset.
- A request arriving on the cycle after LOAD (busy already 0) is accepted normally.
- epc_write is never asserted outside SAVE. pc_write and epc_write are never asserted in the same cycle.

Test Plan:
1. Reset, then pc_req=1 with pc_kind=01 at cycle 5 -> cycle 6: pc_write=1, pc_source=001. Cycle 7: pc_write=0, busy=0 throughout.
2. exc_req=1, exc_cause=01 at cycle 10, L=2 -> epc_write at 11; pc_source=110 with pc_write at 12; pc_write=0 at 13-14; pc_source=100, pc_write=1, exc_done=1 at 15; busy high 11-15, low at 16.
3. exc_req and pc_req (kind 10) both at cycle 3, cause 10 -> pc_req dropped; VEC at cycle 5 uses pc_source=111; no pc_source=010 is ever emitted.
4. During the sequence of test 2, pc_req at 12 and exc_req at 13 -> no extra pc_write; double_fault=1 from 14 and stays set after the sequence; a later reset clears it.
5. Reset asserted at cycle 13 mid-WAIT -> cycle 14: all outputs at reset values, FSM IDLE; pc_req at 15 -> pc_write at 16.
6. Parameter sweep MEM_LATENCY=1 and 15 with cause 11 -> pc_source=101 at VEC; LOAD exactly 3+L cycles after exc_req.
